spi_mitm_sequencer: RTL and testbench
=====================================

SPI_MITM_SEQUENCER -- requirements
Module: spi_mitm_sequencer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, bits per SPI byte (mode 0, MSB first).
REQ-002 SHALL have port sys_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports ss_in, sclk_in, mosi_in, miso_in  input  1 each  bus lines, already synchronized to sys_clk; ss active-low.
REQ-005 SHALL have ports ss_out, sclk_out, mosi_out, miso_out  output  1 each  bus lines driven toward the far side.
REQ-006 SHALL have port inj_data  input  DATA_SIZE  replacement MISO byte.
REQ-007 SHALL have port inj_valid  input  1  inj_data offered.
REQ-008 SHALL have port inj_ready  output  1  holding register empty; accept on inj_valid & inj_ready.
REQ-009 SHALL have port cap_data  output  DATA_SIZE  last complete MOSI byte.
REQ-010 SHALL have port cap_valid  output  1  one-cycle pulse, cap_data newly updated.
REQ-011 SHALL have port busy  output  1  high while state is FWD or INJ.

Function
REQ-012 SHALL drive ss_out, sclk_out, mosi_out combinationally equal to ss_in, sclk_in, mosi_in (zero latency).
REQ-013 SHALL register ss_prev and sclk_prev; ss_fall = ~ss_in & ss_prev; ss_rise = ss_in & ~ss_prev; sclk_rise/sclk_fall likewise, only honoured while ss_in low.
REQ-014 SHALL implement states IDLE, FWD, INJ.
REQ-015 SHALL drive miso_out = miso_in in IDLE and FWD, and tx_shift[DATA_SIZE-1] in INJ.
REQ-016 IDLE: on ss_fall, if holding full -> INJ, tx_shift <= holding, holding emptied; else -> FWD; bit_cnt <= 0.
REQ-017 FWD/INJ: on sclk_rise, rx_shift <= {rx_shift[DATA_SIZE-2:0], mosi_in}; bit_cnt increments.
REQ-018 INJ: on sclk_fall with bit_cnt != 0 and != DATA_SIZE, tx_shift shifts left by one, LSB filled 0.
REQ-019 On sclk_rise with bit_cnt == DATA_SIZE-1: byte complete; next cycle cap_data <= completed byte, cap_valid = 1 for exactly one cycle; bit_cnt <= DATA_SIZE.
REQ-020 On sclk_fall with bit_cnt == DATA_SIZE: bit_cnt <= 0 and next-byte decision per REQ-016 (holding full -> INJ with load, else FWD), no return to IDLE.
REQ-021 On ss_rise in FWD or INJ (any bit_cnt): -> IDLE, bit_cnt <= 0, partial byte discarded, no cap_valid, tx_shift contents dropped; holding register unchanged.
REQ-022 Holding register: one entry; inj_ready = ~holding_full; accept sets holding_full next cycle.
REQ-023 Simultaneous accept and load decision in the same cycle: decision uses holding_full as of that cycle (pre-accept); accepted byte applies to the following byte.
REQ-024 Simultaneous ss_rise and sclk edge: ss_rise takes priority; edge ignored.
REQ-025 cap_data SHALL hold its value between captures.
REQ-026 Byte-complete rising edge SHALL NOT alter miso_out; miso_out changes only at ss_fall or sclk_fall.

Reset
REQ-027 While rst high: state IDLE, bit_cnt 0, holding empty, inj_ready 1, cap_valid 0, cap_data 0, busy 0, tx_shift 0, rx_shift 0, ss_prev 1, sclk_prev 0.
REQ-028 After rst with ss_in already low: SHALL stay IDLE (forwarding) until a fresh ss_fall; no captures for that transaction.
REQ-029 Reset asserted mid-byte SHALL abort the byte with no cap_valid pulse.

Verification
REQ-030 Forward: no injection, ss low, MOSI 0xA5, slave MISO 0x3C -> miso_out tracks miso_in bit-for-bit, one cap_valid with cap_data 0xA5, busy high until ss_rise.
REQ-031 Inject: inj_data 0x5A accepted before ss_fall, slave MISO 0xFF -> master samples 0x5A on 8 rising edges, inj_ready high again from cycle after ss_fall.
REQ-032 Mixed bytes: 3-byte transfer, 0xC3 injected only for byte 2 (accepted during byte 1) -> bytes 1,3 forwarded, byte 2 = 0xC3; three cap_valid pulses with MOSI values.
REQ-033 Abort: ss_rise after 5 rising edges of an injected byte -> IDLE, miso_out = miso_in, no cap_valid, busy 0, next transaction forwarded unless new injection.
REQ-034 Back-pressure: holding full, inj_valid held with 0x11 -> inj_ready 0, no overwrite; holding byte injected; 0x11 accepted the cycle after load.
REQ-035 Reset mid-transfer (ss low, bit 4): rst one cycle -> all outputs at REQ-027 values, no capture until ss high then low.

Source files
------------

// File: rtl/spi_mitm_sequencer.sv
// SPI man-in-the-middle sequencer: forwards SS/SCLK/MOSI untouched, captures
// every complete MOSI byte, and can substitute a queued byte for the slave's
// MISO on a per-byte basis. Mode 0, MSB first.
module spi_mitm_sequencer #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 ss_in,
  input  logic                 sclk_in,
  input  logic                 mosi_in,
  input  logic                 miso_in,
  output logic                 ss_out,
  output logic                 sclk_out,
  output logic                 mosi_out,
  output logic                 miso_out,
  input  logic [DATA_SIZE-1:0] inj_data,
  input  logic                 inj_valid,
  output logic                 inj_ready,
  output logic [DATA_SIZE-1:0] cap_data,
  output logic                 cap_valid,
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] INJ  = 2'd2;

  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_SIZE);

  logic [1:0]           state;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_SIZE-1:0] tx_shift;
  logic [DATA_SIZE-1:0] rx_shift;
  logic [DATA_SIZE-1:0] holding;
  logic                 holding_full;
  logic                 ss_prev;
  logic                 sclk_prev;
  // Set once SS has been seen high after reset, so a transaction already in
  // flight at reset release is forwarded untouched rather than joined midway.
  logic                 ss_armed;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall, accept;

  // Master-side lines pass straight through; only MISO is ever substituted.
  always_comb begin
    ss_out   = ss_in;
    sclk_out = sclk_in;
    mosi_out = mosi_in;
    miso_out = (state == INJ) ? tx_shift[DATA_SIZE-1] : miso_in;
  end

  // Edge detection; clock edges only count while the slave is selected.
  always_comb begin
    ss_fall   = ~ss_in & ss_prev & ss_armed;
    ss_rise   = ss_in & ~ss_prev;
    sclk_rise = ~ss_in & sclk_in & ~sclk_prev;
    sclk_fall = ~ss_in & ~sclk_in & sclk_prev;
    accept    = inj_valid & ~holding_full;
  end

  assign inj_ready = ~holding_full;
  assign busy      = (state != IDLE);

  // Byte sequencing, holding register and capture path.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      holding      <= '0;
      holding_full <= 1'b0;
      cap_data     <= '0;
      cap_valid    <= 1'b0;
      ss_prev      <= 1'b1;
      sclk_prev    <= 1'b0;
      ss_armed     <= 1'b0;
    end else begin
      ss_prev   <= ss_in;
      sclk_prev <= sclk_in;
      cap_valid <= 1'b0;
      if (ss_in) ss_armed <= 1'b1;

      // Accept and load can never coincide: accept needs the register empty,
      // load needs it full, so a load always sees the pre-accept state.
      if (accept) begin
        holding      <= inj_data;
        holding_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            bit_cnt <= '0;
            if (holding_full) begin
              state        <= INJ;
              tx_shift     <= holding;
              holding_full <= 1'b0;
            end else begin
              state <= FWD;
            end
          end
        end
        FWD, INJ: begin
          if (ss_rise) begin
            // Deselect aborts the byte; partial data is thrown away.
            state    <= IDLE;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_SIZE-2:0], mosi_in};
            if (bit_cnt != FULL_CNT) bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
              cap_data  <= {rx_shift[DATA_SIZE-2:0], mosi_in};
              cap_valid <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt == FULL_CNT) begin
              // Byte boundary: choose source for the next byte.
              bit_cnt <= '0;
              if (holding_full) begin
                state        <= INJ;
                tx_shift     <= holding;
                holding_full <= 1'b0;
              end else begin
                state <= FWD;
              end
            end else if (state == INJ && bit_cnt != '0) begin
              tx_shift <= {tx_shift[DATA_SIZE-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mitm_sequencer.sv
// Directed bench for spi_mitm_sequencer: drives an SPI master/slave pair,
// checks MISO seen by the master bit by bit, and scoreboards captured bytes.
module tb_spi_mitm_sequencer;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_in = 1'b1, sclk_in = 1'b0, mosi_in = 1'b0, miso_in = 1'b0;
  logic       ss_out, sclk_out, mosi_out, miso_out;
  logic [7:0] inj_data = 8'h00;
  logic       inj_valid = 1'b0;
  logic       inj_ready;
  logic [7:0] cap_data;
  logic       cap_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  spi_mitm_sequencer #(.DATA_SIZE(8)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .ss_in(ss_in), .sclk_in(sclk_in), .mosi_in(mosi_in), .miso_in(miso_in),
    .ss_out(ss_out), .sclk_out(sclk_out), .mosi_out(mosi_out), .miso_out(miso_out),
    .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .cap_data(cap_data), .cap_valid(cap_valid), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Record every capture pulse, one entry per cycle cap_valid is high.
  always @(negedge sys_clk) begin
    if (!rst && cap_valid) obs_q.push_back(cap_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d);
    inj_data = d; inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
  endtask

  // One SPI byte (or its first nbits). exp_b is what the master must see.
  task automatic xfer(input logic [7:0] mosi_b, input logic [7:0] slv_b,
                      input logic [7:0] exp_b, input int nbits, input logic push);
    for (int i = 7; i >= 8 - nbits; i--) begin
      sclk_in = 1'b0; mosi_in = mosi_b[i]; miso_in = slv_b[i];
      tick(2);
      chk("miso_bit", {31'd0, miso_out}, {31'd0, exp_b[i]});
      chk("mosi_pass", {31'd0, mosi_out}, {31'd0, mosi_b[i]});
      sclk_in = 1'b1;
      tick(2);
    end
    if (nbits == 8) begin
      sclk_in = 1'b0;
      tick(2);
      if (push) exp_q.push_back(mosi_b);
    end
  endtask

  task automatic check_caps();
    logic [7:0] e, o;
    tick(2);
    chk("cap_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("cap_data", {24'd0, o}, {24'd0, e});
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_inj_ready", {31'd0, inj_ready}, 32'd1);
    chk("rst_cap_valid", {31'd0, cap_valid}, 32'd0);
    chk("rst_cap_data", {24'd0, cap_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    miso_in = 1'b1; #1;
    chk("rst_miso_pass", {31'd0, miso_out}, 32'd1);
    chk("rst_ss_pass", {31'd0, ss_out}, 32'd1);
    rst = 1'b0;
    tick(2);

    // Forward only
    ss_in = 1'b0; tick();
    chk("fwd_busy", {31'd0, busy}, 32'd1);
    xfer(8'hA5, 8'h3C, 8'h3C, 8, 1'b1);
    chk("fwd_busy_hold", {31'd0, busy}, 32'd1);
    ss_in = 1'b1; tick();
    chk("fwd_busy_end", {31'd0, busy}, 32'd0);
    check_caps();

    // Single injected byte
    offer(8'h5A);
    chk("inj_ready_full", {31'd0, inj_ready}, 32'd0);
    ss_in = 1'b0; tick();
    chk("inj_ready_after_load", {31'd0, inj_ready}, 32'd1);
    xfer(8'h96, 8'hFF, 8'h5A, 8, 1'b1);
    ss_in = 1'b1; tick();
    check_caps();

    // Three bytes, only the middle one injected
    ss_in = 1'b0; tick();
    offer(8'hC3);
    xfer(8'h11, 8'h22, 8'h22, 8, 1'b1);
    xfer(8'h33, 8'h44, 8'hC3, 8, 1'b1);
    xfer(8'h55, 8'h66, 8'h66, 8, 1'b1);
    ss_in = 1'b1; tick();
    check_caps();

    // Abort after five bits of an injected byte
    offer(8'hE7);
    ss_in = 1'b0; tick();
    xfer(8'hFF, 8'h00, 8'hE7, 5, 1'b0);
    ss_in = 1'b1; sclk_in = 1'b0; tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    miso_in = 1'b0; #1;
    chk("abort_miso0", {31'd0, miso_out}, 32'd0);
    miso_in = 1'b1; #1;
    chk("abort_miso1", {31'd0, miso_out}, 32'd1);
    check_caps();
    ss_in = 1'b0; tick();
    xfer(8'h0F, 8'hA0, 8'hA0, 8, 1'b1);
    ss_in = 1'b1; tick();
    check_caps();

    // Back-pressure on the holding register
    offer(8'h77);
    inj_data = 8'h11; inj_valid = 1'b1;
    tick(3);
    chk("bp_ready_low", {31'd0, inj_ready}, 32'd0);
    ss_in = 1'b0; tick();
    chk("bp_ready_after_load", {31'd0, inj_ready}, 32'd1);
    tick();
    chk("bp_accept_second", {31'd0, inj_ready}, 32'd0);
    inj_valid = 1'b0;
    xfer(8'h01, 8'h00, 8'h77, 8, 1'b1);
    xfer(8'h02, 8'h00, 8'h11, 8, 1'b1);
    ss_in = 1'b1; tick();
    check_caps();

    // Reset mid-byte, then a transaction already selected at release
    ss_in = 1'b0; tick();
    xfer(8'hF0, 8'h55, 8'h55, 4, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_cap_data", {24'd0, cap_data}, 32'd0);
    chk("mrst_inj_ready", {31'd0, inj_ready}, 32'd1);
    xfer(8'h3A, 8'h6B, 8'h6B, 8, 1'b0);
    chk("mrst_still_idle", {31'd0, busy}, 32'd0);
    check_caps();
    ss_in = 1'b1; tick(2);
    ss_in = 1'b0; tick();
    xfer(8'hC5, 8'h12, 8'h12, 8, 1'b1);
    ss_in = 1'b1; tick();
    check_caps();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
